// File: rtl/sevenseg_pkg.sv
// Shared types and defaults for the 7-segment scanner.
// Anode helper builds an active-low one-hot select.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int N_DIGITS_DEF  = 4;
  localparam int SLOT_CYC_DEF  = 50000;
  localparam int BLANK_CYC_DEF = 500;

  function automatic logic [7:0] onehot_n(
    input logic [2:0] idx
  );
    return ~(8'd1 << idx);
  endfunction

endpackage

// File: rtl/sevenseg_scan.sv
// Multiplexed N-digit common-anode display scanner with
// per-digit blanking and frame-aligned double buffering.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS  = N_DIGITS_DEF,
  parameter int SLOT_CYC  = SLOT_CYC_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [4*N_DIGITS-1:0] wr_data,
  input  logic [N_DIGITS-1:0]   wr_dp,
  output logic [3:0]            digit_nib,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  dp_n,
  output logic                  frame_tick
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(SLOT_CYC);
  localparam int DW = 4 * N_DIGITS;

  scan_state_t         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;

  logic [DW-1:0]       pend_data_q, pend_data_d;
  logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic [DW-1:0]       disp_data_q, disp_data_d;
  logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;

  logic [3:0]          nib_q, nib_d;
  logic                dp_n_q, dp_n_d;

  logic                last_blank;
  logic                last_slot;
  logic                last_digit;
  logic                frame_end;
  logic                commit;
  logic [7:0]          an_sel;

  assign last_blank = (cnt_q == CW'(BLANK_CYC - 1));
  assign last_slot  = (cnt_q == CW'(SLOT_CYC - 1));
  assign last_digit = (idx_q == IW'(N_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + CW'(1);
          if (last_blank) state_d = SHOW;
        end
        SHOW: begin
          if (last_slot) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = last_digit ? '0 : idx_q + IW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    an_sel    = onehot_n(3'(idx_q));
    frame_end = en && (state_q == SHOW)
             && last_slot && last_digit;
    an_n      = '1;
    if (state_q == SHOW) an_n = an_sel[N_DIGITS-1:0];
  end

  assign frame_tick = frame_end;

  // Parked scanner has no frame to tear, so commit at once.
  assign commit = pend_valid_q
               && (frame_end || state_q == IDLE);

  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q && !commit;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    if (commit) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
    end
    if (wr_en) begin
      pend_data_d  = wr_data;
      pend_dp_d    = wr_dp;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
    end else begin
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
    end
  end

  always_comb begin
    nib_d  = disp_data_q[{idx_q, 2'b00} +: 4];
    dp_n_d = ~disp_dp_q[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_q  <= '0;
      dp_n_q <= 1'b1;
    end else begin
      nib_q  <= nib_d;
      dp_n_q <= dp_n_d;
    end
  end

  assign digit_nib = nib_q;
  assign dp_n      = dp_n_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with short slots
// (4 digits, 8-cycle slots, 2 blank cycles).
module tb_sevenseg_scan;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  digit_nib;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  sevenseg_scan #(
    .N_DIGITS  (4),
    .SLOT_CYC  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .digit_nib  (digit_nib),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h",
               tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    chk("onehot", 32'($countones(~an_n) <= 1), 1);

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(
    input logic [15:0] d,
    input logic [3:0]  p
  );
    wr_en   = 1'b1;
    wr_data = d;
    wr_dp   = p;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic frame_chk(
    input string       tag,
    input int          n,
    input logic [15:0] exp_nib,
    input logic [3:0]  exp_dp
  );
    logic [15:0] nibs;
    logic [3:0]  dps;
    logic [3:0]  seen;
    nibs = '0;
    dps  = '0;
    seen = '0;
    for (int i = 0; i < n; i++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        if (!an_n[d]) begin
          nibs[d*4 +: 4] = digit_nib;
          dps[d]         = ~dp_n;
          seen[d]        = 1'b1;
        end
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'hF);
    chk({tag, "_nib"}, 32'(nibs), 32'(exp_nib));
    chk({tag, "_dp"}, 32'(dps), 32'(exp_dp));
  endtask

  task automatic to_tick(
    input string       tag,
    input logic [15:0] exp_nib
  );
    int errs;
    bit found;
    errs  = 0;
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      if (frame_tick) found = 1;
      for (int d = 0; d < 4; d++)
        if (!an_n[d] && digit_nib != exp_nib[d*4 +: 4])
          errs++;
    end
    chk({tag, "_tick"}, 32'(found), 1);
    chk({tag, "_old"}, 32'(errs), 0);
  endtask

  task automatic wait_an(
    input string      tag,
    input logic [3:0] val
  );
    bit found;
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      if (an_n == val) found = 1;
    end
    chk({tag, "_wait"}, 32'(found), 1);
  endtask

  initial begin
    int first;
    int pulses;
    int errs;
    rst_n   = 1'b0;
    en      = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    wr_dp   = '0;

    // 1: reset state, first frame timing
    repeat (3) step();
    chk("rst_an", 32'(an_n), 32'hF);
    chk("rst_dp", 32'(dp_n), 1);
    chk("rst_nib", 32'(digit_nib), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    rst_n  = 1'b1;
    first  = 0;
    pulses = 0;
    errs   = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k <= 2)
        chk("t1_blank", 32'(an_n), 32'hF);
      else if (k <= 8)
        chk("t1_show0", 32'(an_n), 32'hE);
      if (digit_nib != 4'h0 || !dp_n) errs++;
      if (frame_tick) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    chk("t1_tick_at", 32'(first), 32);
    chk("t1_pulses", 32'(pulses), 1);
    chk("t1_data0", 32'(errs), 0);

    // 2: write while parked, then enable
    en = 1'b0;
    step();
    chk("t2_park", 32'(an_n), 32'hF);
    wr(16'h1234, 4'b0100);
    step();
    en = 1'b1;
    frame_chk("t2", 32, 16'h1234, 4'b0100);

    // 3: two writes mid-frame, last one wins
    repeat (10) step();
    wr(16'hABCD, 4'b1111);
    wr(16'h5678, 4'b0010);
    to_tick("t3", 16'h1234);
    frame_chk("t3", 32, 16'h5678, 4'b0010);

    // 4: write coincident with frame end
    repeat (5) step();
    wr(16'h9ABC, 4'b0001);
    to_tick("t4", 16'h5678);
    wr(16'hDEF0, 4'b1000);
    frame_chk("t4a", 31, 16'h9ABC, 4'b0001);
    frame_chk("t4b", 32, 16'hDEF0, 4'b1000);

    // 5: drop enable during digit 2
    wait_an("t5", 4'hB);
    en = 1'b0;
    step();
    chk("t5_dark", 32'(an_n), 32'hF);
    errs = 0;
    repeat (6) begin
      step();
      if (an_n != 4'hF || frame_tick) errs++;
    end
    chk("t5_stay", 32'(errs), 0);
    en = 1'b1;
    step();
    chk("t5_b1", 32'(an_n), 32'hF);
    step();
    chk("t5_b2", 32'(an_n), 32'hF);
    step();
    chk("t5_d0", 32'(an_n), 32'hE);

    // 6: asynchronous reset mid-show
    wait_an("t6", 4'hD);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_an", 32'(an_n), 32'hF);
    chk("t6_nib", 32'(digit_nib), 0);
    chk("t6_dp", 32'(dp_n), 1);
    step();
    rst_n = 1'b1;
    frame_chk("t6", 32, 16'h0000, 4'b0000);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
